// File: rtl/modadd_seq.sv
// Modular add/subtract sequencer: runs two operations on a shared mpadder
// (raw op, then correction by M) and selects r = (a +/- b) mod M.
module modadd_seq #(
  parameter int N        = 1027,
  parameter int WAIT_MAX = 64
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic         subtract,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic [N-1:0] in_m,
  output logic [N-1:0] result,
  output logic         done,
  output logic         busy,
  output logic         err,
  output logic         add_start,
  output logic         add_subtract,
  output logic [N-1:0] add_in_a,
  output logic [N-1:0] add_in_b,
  input  logic [N:0]   add_result,
  input  logic         add_done
);

  localparam int CW = $clog2(WAIT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    OP1  = 3'd1,
    W1   = 3'd2,
    OP2  = 3'd3,
    W2   = 3'd4,
    FIN  = 3'd5
  } state_t;

  state_t         state_r, state_nxt_s;
  logic [N-1:0]   a_r, b_r, m_r;
  logic           sub_r;
  logic [N:0]     r1_r, r2_r;
  logic [CW-1:0]  cnt_r;
  logic           timeout_s;
  logic [N-1:0]   sel_s;

  logic [N-1:0]   result_nxt_s, add_a_nxt_s, add_b_nxt_s;
  logic           done_nxt_s, busy_nxt_s, err_nxt_s, add_start_nxt_s, add_sub_nxt_s;

  // A completing add_done always beats the timeout in the same cycle.
  assign timeout_s = (cnt_r == CW'(WAIT_MAX - 1)) && !add_done;

  // Add: keep R2 only if R1 - M did not borrow. Sub: keep R1 unless a - b borrowed.
  assign sel_s = sub_r ? (r1_r[N] ? r1_r[N-1:0] : r2_r[N-1:0])
                       : (r2_r[N] ? r2_r[N-1:0] : r1_r[N-1:0]);

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_nxt_s = OP1;
        else       state_nxt_s = IDLE;
      end
      OP1: state_nxt_s = W1;
      W1: begin
        if (add_done)       state_nxt_s = OP2;
        else if (timeout_s) state_nxt_s = IDLE;
        else                state_nxt_s = W1;
      end
      OP2: state_nxt_s = W2;
      W2: begin
        if (add_done)       state_nxt_s = FIN;
        else if (timeout_s) state_nxt_s = IDLE;
        else                state_nxt_s = W2;
      end
      FIN:     state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    result_nxt_s    = result;
    done_nxt_s      = 1'b0;
    busy_nxt_s      = (state_nxt_s != IDLE) || (state_r == FIN);
    err_nxt_s       = err;
    add_start_nxt_s = 1'b0;
    add_sub_nxt_s   = add_subtract;
    add_a_nxt_s     = add_in_a;
    add_b_nxt_s     = add_in_b;
    case (state_r)
      IDLE: begin
        if (start) err_nxt_s = 1'b0;
        else       err_nxt_s = err;
      end
      OP1: begin
        add_start_nxt_s = 1'b1;
        add_sub_nxt_s   = sub_r;
        add_a_nxt_s     = a_r;
        add_b_nxt_s     = b_r;
      end
      W1, W2: begin
        if (timeout_s) err_nxt_s = 1'b1;
        else           err_nxt_s = err;
      end
      OP2: begin
        add_start_nxt_s = 1'b1;
        add_sub_nxt_s   = ~sub_r;
        add_a_nxt_s     = r1_r[N-1:0];
        add_b_nxt_s     = m_r;
      end
      FIN: begin
        done_nxt_s   = 1'b1;
        result_nxt_s = sel_s;
      end
      default: begin
        done_nxt_s = 1'b0;
      end
    endcase
  end

  // Registered outputs
  always_ff @(posedge clk) begin
    if (!resetn) begin
      result       <= '0;
      done         <= 1'b0;
      busy         <= 1'b0;
      err          <= 1'b0;
      add_start    <= 1'b0;
      add_subtract <= 1'b0;
      add_in_a     <= '0;
      add_in_b     <= '0;
    end else begin
      result       <= result_nxt_s;
      done         <= done_nxt_s;
      busy         <= busy_nxt_s;
      err          <= err_nxt_s;
      add_start    <= add_start_nxt_s;
      add_subtract <= add_sub_nxt_s;
      add_in_a     <= add_a_nxt_s;
      add_in_b     <= add_b_nxt_s;
    end
  end

  // Operand latches, intermediate results and the adder wait counter
  always_ff @(posedge clk) begin
    if (!resetn) begin
      a_r   <= '0;
      b_r   <= '0;
      m_r   <= '0;
      sub_r <= 1'b0;
      r1_r  <= '0;
      r2_r  <= '0;
      cnt_r <= '0;
    end else begin
      if (state_r == IDLE && start) begin
        a_r   <= in_a;
        b_r   <= in_b;
        m_r   <= in_m;
        sub_r <= subtract;
      end
      if (state_r == W1 && add_done) r1_r <= add_result;
      if (state_r == W2 && add_done) r2_r <= add_result;
      if (state_r == OP1 || state_r == OP2)     cnt_r <= '0;
      else if (state_r == W1 || state_r == W2)  cnt_r <= cnt_r + CW'(1);
      else                                      cnt_r <= cnt_r;
    end
  end

endmodule

// File: tb/tb_modadd_seq.sv
// Scoreboard bench for modadd_seq: a fixed-latency adder responder, a
// mod-arithmetic reference model, and a monitor that checks every done/add_start.
module tb_modadd_seq;
  localparam int N        = 1027;
  localparam int WAIT_MAX = 64;
  localparam int L        = 18;

  logic         clk = 1'b0;
  logic         resetn, start, subtract;
  logic [N-1:0] in_a, in_b, in_m;
  logic [N-1:0] result, add_in_a, add_in_b;
  logic         done, busy, err, add_start, add_subtract;
  logic [N:0]   add_result = '0;
  logic         add_done = 1'b0;

  modadd_seq #(.N(N), .WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .resetn(resetn), .start(start), .subtract(subtract),
    .in_a(in_a), .in_b(in_b), .in_m(in_m),
    .result(result), .done(done), .busy(busy), .err(err),
    .add_start(add_start), .add_subtract(add_subtract),
    .add_in_a(add_in_a), .add_in_b(add_in_b),
    .add_result(add_result), .add_done(add_done)
  );

  typedef struct { logic [N-1:0] res; int t0; } exp_t;
  typedef struct { logic s; logic [N-1:0] a; logic [N-1:0] b; } aop_t;
  exp_t exp_q[$];
  aop_t aop_q[$];

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic mute     = 1'b0;
  logic pend     = 1'b0;
  int   cd       = 0;
  logic [N:0] pend_res = '0;

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [N:0] adder_fn(input logic [N-1:0] a, input logic [N-1:0] b, input logic s);
    logic [N-1:0] d;
    if (!s) return {1'b0, a} + {1'b0, b};
    d = a - b;
    return {(a >= b), d};
  endfunction

  // Adder responder: add_done is sampled by the DUT L edges after it samples add_start.
  always @(posedge clk) begin
    add_done <= 1'b0;
    if (pend) begin
      if (cd <= 1) begin
        add_done   <= 1'b1;
        add_result <= pend_res;
        pend       <= 1'b0;
      end else begin
        cd <= cd - 1;
      end
    end
    if (add_start && !mute) begin
      pend     <= 1'b1;
      cd       <= L - 1;
      pend_res <= adder_fn(add_in_a, add_in_b, add_subtract);
    end
  end

  function automatic logic [N-1:0] ref_mod(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic [N-1:0] m, input logic s);
    logic [N+1:0] wa, wb, wm, r;
    wa = {2'b00, a};
    wb = {2'b00, b};
    wm = {2'b00, m};
    if (s) r = (wa + wm - wb) % wm;
    else   r = (wa + wb) % wm;
    return r[N-1:0];
  endfunction

  function automatic logic [N-1:0] rand_n();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = 1'($urandom_range(0, 1));
    return r;
  endfunction

  task automatic chk(input string name, input logic [N:0] act, input logic [N:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got (low 96b) %h, expected %h", name, act[95:0], exp[95:0]);
    end
  endtask

  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic [N-1:0] m,
                       input logic s, input bit want_done, input bit both_ops);
    exp_t e;
    aop_t o;
    logic [N-1:0] r1;
    @(negedge clk);
    start = 1'b1; subtract = s; in_a = a; in_b = b; in_m = m;
    @(posedge clk);
    #1;
    start = 1'b0; in_a = ~a; in_b = ~b; in_m = ~m; subtract = ~s;
    o.s = s; o.a = a; o.b = b;
    aop_q.push_back(o);
    if (both_ops) begin
      r1 = s ? (a - b) : (a + b);
      o.s = ~s; o.a = r1; o.b = m;
      aop_q.push_back(o);
    end
    if (want_done) begin
      e.res = ref_mod(a, b, m, s);
      e.t0  = cyc;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) ok = 1'b1;
    end
    chk("idle_reached", {{N{1'b0}}, ok}, {{N{1'b0}}, 1'b1});
  endtask

  // Monitor: pops expectations whenever the DUT issues an adder op or a result
  initial forever begin
    aop_t o;
    exp_t e;
    @(negedge clk);
    if (add_start) begin
      if (aop_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL extra_add_start: got a=%h b=%h, expected no adder op", add_in_a[63:0], add_in_b[63:0]);
      end else begin
        o = aop_q.pop_front();
        chk("add_in_a", {1'b0, add_in_a}, {1'b0, o.a});
        chk("add_in_b", {1'b0, add_in_b}, {1'b0, o.b});
        chk("add_subtract", (N+1)'(add_subtract), (N+1)'(o.s));
      end
    end
    if (done) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_done: got result=%h, expected no done", result[63:0]);
      end else begin
        e = exp_q.pop_front();
        chk("result", {1'b0, result}, {1'b0, e.res});
        chk("latency", (N+1)'(cyc - e.t0), (N+1)'(2 * L + 5));
        chk("busy_at_done", (N+1)'(busy), (N+1)'(1));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] m, a, b;
    logic s;
    bit   got;
    int   t0, tt;
    resetn = 1'b0; start = 1'b0; subtract = 1'b0;
    in_a = '0; in_b = '0; in_m = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_result", {1'b0, result}, '0);
    chk("rst_flags", (N+1)'({done, busy, err, add_start, add_subtract}), '0);
    chk("rst_add_in", {1'b0, add_in_a | add_in_b}, '0);
    resetn = 1'b1;

    do_op(N'(7), N'(9), N'(13), 1'b0, 1'b1, 1'b1);  wait_idle();
    chk("busy_after_done", (N+1)'(busy), '0);
    do_op(N'(5), N'(4), N'(13), 1'b0, 1'b1, 1'b1);  wait_idle();
    do_op(N'(4), N'(9), N'(13), 1'b1, 1'b1, 1'b1);  wait_idle();
    do_op(N'(9), N'(4), N'(13), 1'b1, 1'b1, 1'b1);  wait_idle();

    m = '0; m[N-2:0] = '1;
    do_op(m - N'(1), m - N'(1), m, 1'b0, 1'b1, 1'b1);  wait_idle();
    do_op(N'(0), m - N'(1), m, 1'b1, 1'b1, 1'b1);      wait_idle();

    // A second start while busy must be dropped, not queued
    do_op(N'(20), N'(30), N'(37), 1'b0, 1'b1, 1'b1);
    repeat (5) @(negedge clk);
    start = 1'b1; subtract = 1'b1; in_a = N'(3); in_b = N'(11); in_m = N'(17);
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    for (int k = 0; k < 16; k++) begin
      if (k % 2 == 0) m = N'($urandom_range(1, 1000));
      else begin m = rand_n(); m[N-1] = 1'b0; if (m == '0) m = N'(1); end
      a = rand_n() % m;
      b = rand_n() % m;
      s = 1'($urandom_range(0, 1));
      do_op(a, b, m, s, 1'b1, 1'b1);
      wait_idle();
    end

    // Silent adder: timeout in W1
    mute = 1'b1;
    do_op(N'(3), N'(4), N'(13), 1'b0, 1'b0, 1'b0);
    t0 = cyc; got = 1'b0; tt = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (err) begin got = 1'b1; tt = cyc; end
    end
    chk("timeout_seen", (N+1)'(got), (N+1)'(1));
    chk("timeout_cycles", (N+1)'(tt - t0), (N+1)'(WAIT_MAX + 1));
    chk("timeout_idle", (N+1)'(busy), '0);
    mute = 1'b0;
    do_op(N'(6), N'(10), N'(13), 1'b0, 1'b1, 1'b1);
    chk("err_cleared", (N+1)'(err), '0);
    wait_idle();

    // Reset while waiting on the second adder op; its late add_done must be ignored
    do_op(N'(8), N'(11), N'(13), 1'b1, 1'b0, 1'b1);
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (aop_q.size() == 0) got = 1'b1;
    end
    chk("second_op_issued", (N+1)'(got), (N+1)'(1));
    repeat (3) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    chk("w2rst_result", {1'b0, result}, '0);
    chk("w2rst_flags", (N+1)'({done, busy, err, add_start, add_subtract}), '0);
    chk("w2rst_add_in", {1'b0, add_in_a | add_in_b}, '0);
    resetn = 1'b1;
    repeat (30) @(negedge clk);
    chk("late_done_busy", (N+1)'(busy), '0);
    chk("late_done_result", {1'b0, result}, '0);

    chk("exp_q_drained", (N+1)'(exp_q.size()), '0);
    chk("aop_q_drained", (N+1)'(aop_q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/modadd_seq.md
Name: modadd_seq

Overview:
- Sequencer that drives one mpadder instance (start/done responder) to perform a full modular add or subtract: r = (a ± b) mod M.
- Issues two adder operations back-to-back: the raw op, then a conditional correction by M. Selects the correct result.
- Sits between the Montgomery top-level controller and the shared 1027-bit adder. Acts as the initiator end of the adder handshake.

Parameters:
- N, 1027, operand width in bits; the adder result is N+1 bits.
- WAIT_MAX, 64, maximum cycles allowed between add_start and add_done before the error flag is raised.

Ports:
- clk  input  1  clock
- resetn  input  1  reset, synchronous, active-low
- start  input  1  one-cycle request; sampled only in IDLE
- subtract  input  1  0: r=(a+b) mod M; 1: r=(a-b) mod M
- in_a  input  N  operand a, required < in_m
- in_b  input  N  operand b, required < in_m
- in_m  input  N  modulus M, required < 2^(N-1)
- result  output  N  modular result, valid from the done pulse until the next done
- done  output  1  one-cycle pulse when result is updated
- busy  output  1  high from the cycle after an accepted start until done
- err  output  1  sticky timeout flag; cleared only by reset or an accepted start
- add_start  output  1  one-cycle pulse to the adder
- add_subtract  output  1  adder operation select
- add_in_a  output  N  adder operand A
- add_in_b  output  N  adder operand B
- add_result  input  N+1  adder result; bit N = carry (add) or no-borrow (subtract: 1 iff A >= B)
- add_done  input  1  adder completion pulse

Behaviour:
- Reset (synchronous, resetn=0 at a clk edge): state=IDLE; result=0, done=0, busy=0, err=0, add_start=0, add_subtract=0, add_in_a=0, add_in_b=0. Reset takes effect in any state and abandons any operation. Any later add_done is ignored while in IDLE.
- Operands are latched into internal registers A, B, M and op flag S when start=1 in IDLE. start in any other state is ignored; it is not queued.
- add_in_a, add_in_b and add_subtract are registered. They are stable from the add_start cycle until add_done.
- States:
  - IDLE: if start, latch inputs, clear err, go to OP1.
  - OP1: drive A, B, add_subtract=S; pulse add_start for 1 cycle; go to W1.
  - W1: wait for add_done. On add_done, capture R1 = add_result and go to OP2.
  - OP2: add_subtract = ~S; operands are R1[N-1:0] and M. For add: R1 - M. For sub: R1 + M. Pulse add_start; go to W2.
  - W2: on add_done, capture R2 and go to FIN.
  - FIN: select the result, pulse done, go to IDLE.
- Selection rules:
  - add (S=0): a+b < 2^N, so R1[N]=0. If R2[N]=1 (no borrow, R1 >= M), result = R2[N-1:0]; otherwise result = R1[N-1:0].
  - sub (S=1): if R1[N]=1 (no borrow, a >= b), result = R1[N-1:0]; otherwise result = R2[N-1:0] (wrapped difference + M, carry discarded).
- Both adder ops always execute, so latency is constant for a fixed adder latency L: done rises 2L+5 cycles after the start edge.
- Timeout: a counter is cleared on each add_start and increments in W1/W2. When it reaches WAIT_MAX without add_done: set err=1, force IDLE, no done pulse, result unchanged.
- add_done seen in OP1/OP2/FIN/IDLE is ignored.
- add_done arriving in the same cycle as a timeout hit: add_done wins.
- busy=1 in OP1, W1, OP2, W2, FIN; done and busy are both high in the FIN output cycle.

Test Plan:
- Reset, then start add a=7, b=9, M=13 -> exactly one add_start with operands (7,9,sub=0), then one with (16,13,sub=1); done pulse with result=3, busy low after.
- add a=5, b=4, M=13 -> R2 borrows, result=9; latency equals 2L+5 with a fixed-latency adder model (L=18).
- sub a=4, b=9, M=13 -> R1[N]=0, second op is (2^N-5)+13 with sub=0, result=8; sub a=9, b=4 -> result=5.
- Full width: M=2^(N-1)-1, a=b=M-1, add -> result=M-2; sub a=0, b=M-1 -> result=1.
- start pulsed again while busy with different operands -> ignored; result matches the first request; exactly two add_start pulses.
- Adder model never asserts add_done -> err=1 after WAIT_MAX cycles in W1, no done, back in IDLE; next start clears err and completes. Separately, resetn=0 during W2 -> all outputs 0 next cycle, a late add_done is ignored.
